// File: rtl/tama_pkg.sv
// Shared encodings for the pet status blocks: mood states, stat indices,
// and the dwell counter width.
package tama_pkg;

   typedef enum logic [2:0] {
      CONTENT = 3'd0,
      NEEDY   = 3'd1,
      SLEEPY  = 3'd2,
      SICK    = 3'd3,
      DEAD    = 3'd4
   } mood_t;

   localparam int unsigned HUNGER    = 0;
   localparam int unsigned HAPPINESS = 1;
   localparam int unsigned HEALTH    = 2;
   localparam int unsigned HYGIENE   = 3;
   localparam int unsigned ENERGY    = 4;
   localparam int unsigned SOCIAL    = 5;

   localparam int unsigned NUM_STATS = 6;

   // Wide enough for DWELL_CYCLES up to 2^27-1.
   localparam int unsigned DWELL_W = 27;

endpackage

// File: rtl/pet_mood_stat_max6.sv
// Combinational max-and-index finder over six packed 4-bit levels;
// ties resolve to the lowest index.
module stat_max6
   import tama_pkg::*;
(
   input  logic [4*NUM_STATS-1:0] levels,
   output logic [3:0]             max_level,
   output logic [2:0]             max_index
);

   always_comb begin
      max_level = levels[3:0];
      max_index = '0;
      // Strict compare keeps the earlier index on ties.
      for (int unsigned i = 1; i < NUM_STATS; i++) begin
         if (levels[i*4 +: 4] > max_level) begin
            max_level = levels[i*4 +: 4];
            max_index = 3'(i);
         end
      end
   end

endmodule

// File: rtl/pet_mood.sv
// Most-urgent-need finder, dwell-debounced mood FSM and sticky alert.
// Optional macro PET_DEATH_EN enables the absorbing DEAD mood.
module pet_mood
   import tama_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 27_000_000,
   parameter int unsigned WARN_LEVEL   = 10,
   parameter int unsigned CRIT_LEVEL   = 14,
   parameter int unsigned SICK_COUNT   = 3
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] hunger,
   input  logic [3:0] happiness,
   input  logic [3:0] health,
   input  logic [3:0] hygiene,
   input  logic [3:0] energy,
   input  logic [3:0] social,
   input  logic       alert_ack,
   output logic [2:0] mood,
   output logic       mood_changed,
   output logic       alert,
   output logic [2:0] worst_stat,
   output logic [3:0] worst_level
);

   localparam logic [3:0]         WARN_L     = 4'(WARN_LEVEL);
   localparam logic [3:0]         CRIT_L     = 4'(CRIT_LEVEL);
   localparam logic [2:0]         SICK_N     = 3'(SICK_COUNT);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

   logic [4*NUM_STATS-1:0] levels;
   logic [3:0]             max_level;
   logic [2:0]             max_index;
   logic [2:0]             crit_cnt_d;
   logic                   warn_any_d;

   logic [3:0] worst_level_q;
   logic [2:0] worst_stat_q;
   logic [2:0] crit_cnt_q;
   logic       warn_any_q;
   logic       health_crit_q;
   logic       energy_crit_q;
   logic       dead_q;

   mood_t              mood_q, mood_d, target, prev_target_q;
   logic [DWELL_W-1:0] cnt_q, cnt_d, run_cnt;
   logic               changed_d, changed_q;
   logic               alert_d, alert_q;
   logic               is_dead, go_dead, crit_rise, mood_set;

   assign levels = {social, energy, hygiene, health, happiness, hunger};

   stat_max6 u_stat_max6 (
      .levels    (levels),
      .max_level (max_level),
      .max_index (max_index)
   );

   always_comb begin
      crit_cnt_d = '0;
      warn_any_d = 1'b0;
      for (int unsigned i = 0; i < NUM_STATS; i++) begin
         if (levels[i*4 +: 4] >= CRIT_L) crit_cnt_d = crit_cnt_d + 3'd1;
         if (levels[i*4 +: 4] >= WARN_L) warn_any_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         worst_level_q <= '0;
         worst_stat_q  <= '0;
         crit_cnt_q    <= '0;
         warn_any_q    <= 1'b0;
         health_crit_q <= 1'b0;
         energy_crit_q <= 1'b0;
         dead_q        <= 1'b0;
      end else begin
         worst_level_q <= max_level;
         worst_stat_q  <= max_index;
         crit_cnt_q    <= crit_cnt_d;
         warn_any_q    <= warn_any_d;
         health_crit_q <= (health >= CRIT_L);
         energy_crit_q <= (energy >= CRIT_L);
         dead_q        <= (health == 4'hF) && (hunger == 4'hF);
      end
   end

   always_comb begin
      target = CONTENT;
`ifdef PET_DEATH_EN
      if (dead_q)                                          target = DEAD;
      else if (health_crit_q || (crit_cnt_q >= SICK_N))    target = SICK;
`else
      if (health_crit_q || (crit_cnt_q >= SICK_N))         target = SICK;
`endif
      else if (energy_crit_q)                              target = SLEEPY;
      else if (warn_any_q)                                 target = NEEDY;
   end

`ifdef PET_DEATH_EN
   assign is_dead = (mood_q == DEAD);
   assign go_dead = (target == DEAD);
`else
   assign is_dead = 1'b0;
   assign go_dead = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mood_q        <= CONTENT;
         prev_target_q <= CONTENT;
         cnt_q         <= '0;
         changed_q     <= 1'b0;
         alert_q       <= 1'b0;
      end else begin
         mood_q        <= mood_d;
         prev_target_q <= target;
         cnt_q         <= cnt_d;
         changed_q     <= changed_d;
         alert_q       <= alert_d;
      end
   end

   // run_cnt is the stored count already cleared when target just changed,
   // so the first cycle of a new target counts as one dwell cycle.
   always_comb begin
      mood_d    = mood_q;
      cnt_d     = cnt_q;
      changed_d = 1'b0;
      run_cnt   = (target != prev_target_q) ? '0 : cnt_q;
      if (is_dead) begin
         cnt_d = '0;
      end else if (go_dead) begin
         mood_d    = DEAD;
         changed_d = 1'b1;
         cnt_d     = '0;
      end else if (target == mood_q) begin
         cnt_d = '0;
      end else if (run_cnt == DWELL_LAST) begin
         mood_d    = target;
         changed_d = 1'b1;
         cnt_d     = '0;
      end else begin
         cnt_d = run_cnt + 1'b1;
      end
   end

   always_comb begin
      crit_rise = (max_level >= CRIT_L) && (worst_level_q < CRIT_L);
      mood_set  = changed_d && ((mood_d == SICK) || (mood_d == DEAD));
      alert_d   = alert_q;
      if (alert_ack)                        alert_d = 1'b0;
      if (crit_rise || mood_set || is_dead) alert_d = 1'b1;
   end

   assign mood         = mood_q;
   assign mood_changed = changed_q;
   assign alert        = alert_q;
   assign worst_stat   = worst_stat_q;
   assign worst_level  = worst_level_q;

endmodule

// File: doc/pet_mood.md
Name: pet_mood

Overview:
Downstream consumer of the six 4-bit need levels produced by the stats block (0 = fully satisfied, 15 = critical).
- Evaluates the six levels every cycle and reports the most urgent need.
- Drives a debounced mood state machine with dwell-time hysteresis.
- Raises a sticky alert that the UI/display layer acknowledges.

Parameters:
DWELL_CYCLES, 27_000_000, consecutive cycles a new target mood must persist before mood changes (1 s at 27 MHz); legal range 1 to 2^27-1
WARN_LEVEL, 10, need level at or above which a stat counts as "warning"
CRIT_LEVEL, 14, need level at or above which a stat counts as "critical"
SICK_COUNT, 3, number of simultaneously critical stats that forces SICK

Ports:
clk  input  1  27 MHz clock
reset  input  1  asynchronous, active-high
hunger  input  4  need level
happiness  input  4  need level
health  input  4  need level
hygiene  input  4  need level
energy  input  4  need level
social  input  4  need level
alert_ack  input  1  single-cycle acknowledge from UI
mood  output  3  current mood encoding
mood_changed  output  1  one-cycle pulse on every mood update
alert  output  1  sticky alert flag
worst_stat  output  3  index of highest need (0 hunger … 5 social)
worst_level  output  4  value of that stat

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values: mood=CONTENT(0), mood_changed=0, alert=0, worst_stat=0, worst_level=0, dwell counter=0, pipeline registers=0.
- Stage 1 (1-cycle latency) registers:
  - worst_level: max of the six inputs.
  - worst_stat: index of the max; ties resolve to the lowest index.
  - crit_cnt: 3-bit count of stats >= CRIT_LEVEL.
  - warn_any: any stat >= WARN_LEVEL.
  - health_crit and energy_crit flags.
- Target mood from stage-1 registers, highest priority first:
  - DEAD(4): health==15 && hunger==15; only when the feature is enabled.
  - SICK(3): health_crit || crit_cnt >= SICK_COUNT.
  - SLEEPY(2): energy_crit.
  - NEEDY(1): warn_any.
  - CONTENT(0): otherwise.
- Mood FSM states: CONTENT, NEEDY, SLEEPY, SICK, DEAD.
  - target == mood: dwell counter cleared.
  - target != mood: counter increments each cycle. It clears whenever target changes value between consecutive cycles.
  - When the counter reaches DWELL_CYCLES-1 with target still unchanged, mood <= target on the next edge, mood_changed pulses for 1 cycle, and the counter clears.
  - Minimum change latency from input edge to mood update: 1 + DWELL_CYCLES cycles.
- DEAD: entered immediately, bypassing dwell, 2 cycles after the input edge. DEAD is absorbing until reset; inputs are ignored.
- Alert set events, each evaluated on the mood update cycle or stage-1 register cycle:
  - mood becomes SICK or DEAD.
  - worst_level rises from < CRIT_LEVEL to >= CRIT_LEVEL.
- Alert clear: alert_ack=1 clears alert. If a set event and alert_ack occur in the same cycle, the set wins and alert stays 1. alert_ack with alert=0 has no effect.
- In DEAD, alert is forced to 1 and ack is ignored.
- Reset mid-dwell discards the partial count; the stage-1 pipeline refills 1 cycle after reset deasserts.

Optional Feature:
PET_DEATH_EN
- Defined: DEAD state exists and behaves as above.
- Undefined: the DEAD condition maps to SICK; mood never exceeds 3, and alert_ack is always honoured.

Decomposition:
- Package tama_pkg holds:
  - mood encodings: CONTENT=0, NEEDY=1, SLEEPY=2, SICK=3, DEAD=4.
  - stat index constants: HUNGER=0, HAPPINESS=1, HEALTH=2, HYGIENE=3, ENERGY=4, SOCIAL=5.
  - NUM_STATS=6.
- Sub-module stat_max6: combinational max-and-index finder with lowest-index tie-break, instantiated in stage 1.

Test Plan:
Use DWELL_CYCLES=4.
- All stats 0, then hunger=10 held -> worst_stat=0, worst_level=10 after 1 cycle; mood=NEEDY with mood_changed pulse 5 cycles after the edge.
- hunger=10 for 2 cycles, then back to 0 -> mood stays CONTENT, no pulse.
- hygiene=14, social=14, happiness=14 -> crit_cnt=3, mood=SICK after dwell, alert=1; ack pulse -> alert=0.
- energy=14 and health=14 simultaneously -> mood=SICK, not SLEEPY. Also: hunger=12, social=12 -> worst_stat=0 (tie-break).
- Alert pending, then new crit crossing coincident with alert_ack -> alert remains 1.
- With PET_DEATH_EN: health=15, hunger=15 -> mood=DEAD 2 cycles later; acks ignored; inputs cleared -> stays DEAD; reset -> CONTENT. Without the macro -> mood=SICK.
